// File: rtl/disparity_pkg.sv
// Shared constants, state encoding and the visualisation scaler for the
// disparity read-back path.
package disparity_pkg;

    localparam int DISP_COLS   = 240;
    localparam int DISP_ROWS   = 320;
    localparam int DISP_PIXELS = DISP_COLS * DISP_ROWS;
    localparam int DISP_ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } disp_rd_state_t;

    // Left-shift a disparity for display, clamping to the 8-bit range.
    function automatic logic [7:0] disp_scale(input logic [7:0] din, input int sh);
        logic [15:0] wide;
        wide = {8'd0, din} << sh;
        return (wide > 16'd255) ? 8'hFF : wide[7:0];
    endfunction

endpackage

// File: rtl/disparity_fifo.sv
// Show-ahead FIFO holding {last, data} words between the BRAM read pipe
// and the output stream. Head word is visible on rdata_o while non-empty.
module disparity_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_en, rd_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;

    // Storage array; contents are don't-care until counted in.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/disparity_reader.sv
// Sweeps the matcher's disparity BRAM in raster order after each frame-done
// pulse and streams the (optionally scaled) values out on ready/valid.
// Reads are only issued when the FIFO is guaranteed room for them, so
// backpressure never drops or repeats a sample.
module disparity_reader
    import disparity_pkg::*;
#(
    parameter int COLS         = DISP_COLS,
    parameter int ROWS         = DISP_ROWS,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int SCALE_SHIFT  = 0
) (
    input  logic                   clk_100mhz,
    input  logic                   sys_rst,
    input  logic                   frame_ready_in,
    output logic                   reading,
    output logic [DISP_ADDR_W-1:0] ssd_addr,
    input  logic [7:0]             ssd_dout,
    output logic [7:0]             m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int PIXELS = ROWS * COLS;
    localparam int CW     = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
    localparam int FCW    = $clog2(FIFO_DEPTH + 1);

    disp_rd_state_t           state_q, state_d;
    logic [DISP_ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                     reading_q, reading_d;
    logic                     pending_q, pending_d;
    logic                     frame_done_q, frame_done_d;
    logic [READ_LATENCY-1:0]  vld_pipe_q, last_pipe_q;

    logic                     issue, issue_last, pop;
    logic [CW-1:0]            inflight, credit_used;
    logic [FCW-1:0]           fifo_count;
    logic                     fifo_full, fifo_empty, fifo_push;
    logic [8:0]               fifo_rdata;

    assign pop       = m_valid && m_ready;
    assign fifo_push = vld_pipe_q[READ_LATENCY-1];

    // Reads still travelling through the BRAM latency, including the one landing now.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(vld_pipe_q[i]);
    end

    assign credit_used = inflight + CW'(fifo_count) - CW'(pop);

    // Frame sequencing: start on pulse or remembered pulse, issue while credit allows, drain.
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        reading_d    = reading_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        issue        = 1'b0;
        issue_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_ready_in || pending_q) begin
                    state_d   = STREAM;
                    reading_d = 1'b1;
                    rd_ptr_d  = '0;
                    pending_d = 1'b0;
                end
            end
            STREAM: begin
                if (frame_ready_in) pending_d = 1'b1;
                if (credit_used < CW'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    // The pointer parks on the final address so ssd_addr stays in range.
                    if (rd_ptr_q == DISP_ADDR_W'(PIXELS - 1)) begin
                        issue_last = 1'b1;
                        state_d    = DRAIN;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (frame_ready_in) pending_d = 1'b1;
                // The tagged word is the very last read, so its pop means pipe and FIFO are empty.
                if (pop && m_last) begin
                    state_d      = IDLE;
                    reading_d    = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset abandons any frame in progress.
    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            reading_q    <= 1'b0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            reading_q    <= reading_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Token pipe matching the BRAM latency; the exit token captures ssd_dout.
    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            vld_pipe_q[0]  <= issue;
            last_pipe_q[0] <= issue_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
            end
        end
    end

    disparity_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk_i   (clk_100mhz),
        .rst_i   (sys_rst),
        .push_i  (fifo_push),
        .wdata_i ({last_pipe_q[READ_LATENCY-1], disp_scale(ssd_dout, SCALE_SHIFT)}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A landing read into a full FIFO would lose a sample; the credit check rules it out.
    assert property (@(posedge clk_100mhz) disable iff (sys_rst)
        !(fifo_push && fifo_full && !pop));

    assign m_valid    = !fifo_empty;
    assign m_data     = m_valid ? fifo_rdata[7:0] : 8'd0;
    assign m_last     = m_valid && fifo_rdata[8];
    assign ssd_addr   = rd_ptr_q;
    assign reading    = reading_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disparity_reader.sv
// Scoreboard bench: the stimulus side queues the pixel stream each frame
// should produce; monitors pop and compare on every output handshake.
module tb_disparity_reader;

    localparam int NC = 24, NR = 32, NPIX = NC * NR;
    localparam int SC = 4, SR = 2, SPIX = SC * SR;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1, frame_ready_in = 1'b0, m_ready = 1'b1;
    logic        reading, m_valid, m_last, busy, frame_done;
    logic [16:0] ssd_addr;
    logic [7:0]  ssd_dout, m_data, d1;

    logic        s_frame = 1'b0, s_ready = 1'b1;
    logic        s_reading, s_valid, s_last, s_busy, s_fd;
    logic [16:0] s_addr;
    logic [7:0]  s_dout = 8'd0, s_data;

    int tests = 0, fails = 0;
    int sb[$];
    int s_sb[$];
    int beat_idx = 0, rmode = 0, stall_left = 0;
    bit fd_due = 0, prev_stall = 0;
    int prev_word = 0;

    disparity_reader #(.COLS(NC), .ROWS(NR)) u_dut (
        .clk_100mhz(clk), .sys_rst(sys_rst), .frame_ready_in(frame_ready_in),
        .reading(reading), .ssd_addr(ssd_addr), .ssd_dout(ssd_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .frame_done(frame_done));

    disparity_reader #(.COLS(SC), .ROWS(SR), .SCALE_SHIFT(2)) u_sdut (
        .clk_100mhz(clk), .sys_rst(sys_rst), .frame_ready_in(s_frame),
        .reading(s_reading), .ssd_addr(s_addr), .ssd_dout(s_dout),
        .m_data(s_data), .m_valid(s_valid), .m_ready(s_ready), .m_last(s_last),
        .busy(s_busy), .frame_done(s_fd));

    always #5 clk = ~clk;

    // BRAM model: dout = addr[7:0], two cycles after the address.
    always @(posedge clk) begin
        d1       <= ssd_addr[7:0];
        ssd_dout <= d1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Downstream ready: always, 30% random stalls, or one 50-cycle stall at beat 100.
    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            1: m_ready = ($urandom_range(0, 99) >= 30);
            2: if (beat_idx == 100 && stall_left > 0) begin
                   m_ready = 1'b0;
                   stall_left--;
               end else m_ready = 1'b1;
            default: m_ready = 1'b1;
        endcase
    end

    // Main monitor: data/last order, frame_done timing, stall stability.
    initial forever begin
        @(negedge clk);
        if (sys_rst) begin
            sb.delete();
            beat_idx = 0; fd_due = 0; prev_stall = 0;
        end else begin
            if (fd_due || frame_done) chk("frame_done one cycle after last", int'(frame_done), int'(fd_due));
            fd_due = 0;
            if (prev_stall) begin
                chk("stable during stall", {m_valid, m_last, m_data}, {1'b1, prev_word[8:0]});
                chk("fifo count within depth", int'(u_dut.u_fifo.count_o <= 4), 1);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) chk("beat with nothing expected", sb.size(), 1);
                else chk("beat {last,data}", {m_last, m_data}, sb.pop_front());
                beat_idx++;
                if (m_last) begin
                    fd_due = 1;
                    beat_idx = 0;
                    chk("reading held at last beat", int'(reading), 1);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_last, m_data};
        end
    end

    // Scaled-instance monitor.
    initial forever begin
        @(negedge clk);
        if (!sys_rst && s_valid && s_ready) begin
            if (s_sb.size() == 0) chk("scaled beat with nothing expected", s_sb.size(), 1);
            else chk("scaled beat {last,data}", {s_last, s_data}, s_sb.pop_front());
        end
    end

    task automatic pulse();
        @(posedge clk); #1 frame_ready_in = 1'b1;
        @(posedge clk); #1 frame_ready_in = 1'b0;
    endtask

    task automatic start_frame();
        for (int k = 0; k < NPIX; k++) sb.push_back(((k == NPIX - 1) ? 256 : 0) + (k % 256));
        pulse();
    endtask

    task automatic wait_done(input bit sel);
        int c = 0;
        @(negedge clk);
        while (!(sel ? s_fd : frame_done) && c < 6000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 6000) chk("frame_done timeout", int'(sel ? s_fd : frame_done), 1);
    endtask

    task automatic wait_beat(input int n);
        int c = 0;
        while (beat_idx != n && c < 6000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 6000) chk("beat wait timeout", beat_idx, n);
    endtask

    task automatic scaled_frame(input int v);
        int e;
        e = (v * 4 > 255) ? 255 : v * 4;
        s_dout = 8'(v);
        for (int k = 0; k < SPIX; k++) s_sb.push_back(((k == SPIX - 1) ? 256 : 0) + e);
        @(posedge clk); #1 s_frame = 1'b1;
        @(posedge clk); #1 s_frame = 1'b0;
        wait_done(1'b1);
        chk("scaled frame fully consumed", s_sb.size(), 0);
    endtask

    initial begin
        int cnt;
        // Reset values, and a pulse during reset is ignored.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset reading", int'(reading), 0);
        chk("reset ssd_addr", int'(ssd_addr), 0);
        chk("reset m_valid", int'(m_valid), 0);
        chk("reset m_last", int'(m_last), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset frame_done", int'(frame_done), 0);
        @(posedge clk); #1 frame_ready_in = 1'b1;
        @(posedge clk); #1 frame_ready_in = 1'b0; sys_rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("pulse under reset ignored", int'(busy), 0);

        // Frame A: full-rate, latency profile.
        rmode = 0;
        start_frame();
        @(negedge clk);
        chk("reading at cycle 1", int'(reading), 1);
        chk("no valid at cycle 1", int'(m_valid), 0);
        @(negedge clk);
        chk("no valid at cycle 2", int'(m_valid), 0);
        @(negedge clk);
        chk("no valid at cycle 3", int'(m_valid), 0);
        @(negedge clk);
        chk("first valid at cycle 4", int'(m_valid), 1);
        wait_done(1'b0);
        chk("reading dropped at frame_done", int'(reading), 0);
        chk("idle at frame_done", int'(busy), 0);
        chk("frame A consumed", sb.size(), 0);

        // Frame B: random backpressure.
        rmode = 1;
        start_frame();
        wait_done(1'b0);
        chk("frame B consumed", sb.size(), 0);

        // Frame C: long stall at beat 100.
        rmode = 2; stall_left = 50;
        start_frame();
        cnt = 0;
        while (stall_left > 40 && cnt < 6000) begin @(negedge clk); cnt++; end
        @(negedge clk);
        chk("ssd_addr frozen during stall", int'(ssd_addr), 104);
        chk("valid held during stall", int'(m_valid), 1);
        wait_done(1'b0);
        chk("frame C consumed", sb.size(), 0);

        // Frame D: extra pulse mid-frame queues a back-to-back frame.
        rmode = 0;
        start_frame();
        wait_beat(500);
        start_frame();
        wait_done(1'b0);
        chk("one idle cycle: reading low", int'(reading), 0);
        @(negedge clk);
        chk("second frame reading", int'(reading), 1);
        chk("second frame starts at 0", int'(ssd_addr), 0);
        wait_done(1'b0);
        chk("frame D pair consumed", sb.size(), 0);

        // Frame E: reset mid-frame, then a clean restart.
        start_frame();
        wait_beat(300);
        @(posedge clk); #1 sys_rst = 1'b1;
        @(posedge clk); #1 sys_rst = 1'b0;
        @(negedge clk);
        chk("after reset m_valid", int'(m_valid), 0);
        chk("after reset reading", int'(reading), 0);
        chk("after reset busy", int'(busy), 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_last || frame_done) cnt++;
        end
        chk("no last/frame_done after abort", cnt, 0);
        rmode = 1;
        start_frame();
        wait_done(1'b0);
        chk("restart frame consumed", sb.size(), 0);

        // Scaled instance: 10<<2 = 40, 70<<2 saturates.
        scaled_frame(10);
        scaled_frame(70);
        @(negedge clk);
        chk("scaled addr parks on final pixel", int'(s_addr), SPIX - 1);
        chk("scaled reading released", int'(s_reading), 0);
        chk("scaled idle", int'(s_busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
